axi_sram_slave: RTL and testbench

- AXI3 slave memory model. It is the responder end of the CPU core's AXI master port, with the same signal set and widths.
- Used in simulation and FPGA test harnesses to back the core with a word-addressed SRAM.
- Serves one burst at a time, read or write, with round-robin arbitration.
- Supports INCR, WRAP and FIXED bursts of 1–16 beats.

---
 rtl/axi_sram_slave.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave memory model backed by a word-addressed SRAM.
// Serves one read or write burst at a time (FIXED/INCR/WRAP, 1-16 beats) with
// round-robin arbitration between AR and AW.
// Optional build macro AXI_SLAVE_RAND_STALL_EN inserts LFSR-driven wait states.
// INIT_FILE names an optional memory image; the harness preloads mem hierarchically.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h1FC0_0000,
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter              INIT_FILE   = ""
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RDATA, S_WDATA, S_WRESP} state_t;

  state_t      state_q, state_d;
  logic        prefer_rd_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  cnt_q;
  logic [1:0]  worst_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Address after one beat; reserved burst type 2'b11 steps like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [3:0] ln, input logic [1:0] bt);
    logic [31:0] step, mask, res;
    step = 32'd1 << sz;
    mask = (({28'd0, ln} + 32'd1) << sz) - 32'd1;
    case (bt)
      BURST_FIXED: res = a;
      BURST_WRAP:  res = (a & ~mask) | ((a + step) & mask);
      default:     res = a + step;
    endcase
    return res;
  endfunction

  // Response codes are ordered so that the numerically larger one is worse.
  function automatic logic [1:0] worse(input logic [1:0] x, input logic [1:0] y);
    return (x > y) ? x : y;
  endfunction

  // Per-beat decode of the current address and the latched burst shape.
  logic [29:0]      word_off;
  logic             addr_oob;
  logic             cfg_err;
  logic [1:0]       beat_resp;
  logic [IDX_W-1:0] idx;
  logic             last_beat;
  logic             wlast_bad;

  assign word_off  = 30'((addr_q - BASE_ADDR) >> 2);
  assign addr_oob  = (addr_q < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));
  assign cfg_err   = (size_q > 3'd2) ||
                     ((burst_q == BURST_WRAP) && !(len_q inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign beat_resp = addr_oob ? RESP_DECERR : (cfg_err ? RESP_SLVERR : RESP_OKAY);
  assign idx       = word_off[IDX_W-1:0];
  assign last_beat = (cnt_q == len_q);
  assign wlast_bad = (wlast != last_beat);

  logic rdy_open;
  logic r_open;

`ifdef AXI_SLAVE_RAND_STALL_EN
  logic [15:0] lfsr_q;
  logic        rv_hold_q;

  // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) picking stall cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= 16'hACE1;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Remembers an offered-but-untaken read beat so rvalid cannot drop early.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rv_hold_q <= 1'b0;
    else          rv_hold_q <= rvalid & ~rready;
  end

  assign rdy_open = |lfsr_q[1:0];
  assign r_open   = rv_hold_q | (|lfsr_q[3:2]);
`else
  assign rdy_open = 1'b1;
  assign r_open   = 1'b1;
`endif

  logic ar_hs, aw_hs, r_hs, w_hs;
  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign r_hs  = rvalid & rready;
  assign w_hs  = wvalid & wready;

  // Next-state and handshake outputs; arbitration winner decided in IDLE.
  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    rid     = 4'd0;
    rdata   = 32'd0;
    rresp   = RESP_OKAY;
    rlast   = 1'b0;
    bvalid  = 1'b0;
    bid     = 4'd0;
    bresp   = RESP_OKAY;
    case (state_q)
      S_IDLE: begin
        arready = rdy_open & arvalid & (prefer_rd_q | ~awvalid);
        awready = rdy_open & awvalid & (~prefer_rd_q | ~arvalid);
        if (arvalid & arready)      state_d = S_RDATA;
        else if (awvalid & awready) state_d = S_WDATA;
      end
      S_RDATA: begin
        rvalid = r_open;
        if (rvalid) begin
          rid   = id_q;
          rresp = beat_resp;
          rlast = last_beat;
          rdata = (beat_resp == RESP_OKAY) ? mem[idx] : 32'd0;
        end
        if (rvalid && rready && last_beat) state_d = S_IDLE;
      end
      S_WDATA: begin
        wready = rdy_open;
        if (wvalid && wready && last_beat) state_d = S_WRESP;
      end
      S_WRESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = worst_q;
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst context: latched on address handshake, stepped on each data beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      prefer_rd_q <= 1'b1;
      id_q        <= 4'd0;
      addr_q      <= 32'd0;
      len_q       <= 4'd0;
      size_q      <= 3'd0;
      burst_q     <= 2'd0;
      cnt_q       <= 4'd0;
      worst_q     <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (ar_hs) begin
        prefer_rd_q <= 1'b0;
        id_q        <= arid;
        addr_q      <= araddr;
        len_q       <= arlen;
        size_q      <= arsize;
        burst_q     <= arburst;
        cnt_q       <= 4'd0;
        worst_q     <= RESP_OKAY;
      end else if (aw_hs) begin
        prefer_rd_q <= 1'b1;
        id_q        <= awid;
        addr_q      <= awaddr;
        len_q       <= awlen;
        size_q      <= awsize;
        burst_q     <= awburst;
        cnt_q       <= 4'd0;
        worst_q     <= RESP_OKAY;
      end else if (r_hs) begin
        addr_q <= next_addr(addr_q, size_q, len_q, burst_q);
        cnt_q  <= cnt_q + 4'd1;
      end else if (w_hs) begin
        addr_q  <= next_addr(addr_q, size_q, len_q, burst_q);
        cnt_q   <= cnt_q + 4'd1;
        worst_q <= worse(worse(worst_q, beat_resp), wlast_bad ? RESP_SLVERR : RESP_OKAY);
      end
    end
  end

  // Byte-lane write of accepted W beats; error beats leave memory untouched.
  always_ff @(posedge aclk) begin
    if (w_hs && (beat_resp == RESP_OKAY)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed plus randomized bursts against a behavioural
// memory/response model of the AXI SRAM slave.
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h1FC0_0000;
  localparam int          DEPTH = 65536;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [3:0]  arlen = '0, awlen = '0, arcache = '0, awcache = '0, wstrb = '0;
  logic [2:0]  arsize = '0, awsize = '0, arprot = '0, awprot = '0;
  logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0, rresp, bresp;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference rules: address stepping, per-beat response, word index.
  function automatic logic [31:0] m_next(input logic [31:0] a, input int sz, input int ln, input int bt);
    logic [31:0] step, bnd;
    step = 32'd1 << sz;
    bnd  = 32'(ln + 1) * step;
    if (bt == 0)      return a;
    else if (bt == 2) return (a & ~(bnd - 1)) | ((a + step) & (bnd - 1));
    else              return a + step;
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a, input int sz, input int ln, input int bt);
    if (a < BASE || ((a - BASE) >> 2) >= DEPTH) return 2'b11;
    if (sz > 2 || (bt == 2 && !(ln inside {1, 3, 7, 15}))) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int m_word(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic set_ar(input logic [3:0] id, input logic [31:0] a, input int ln, input int sz, input int bt);
    arid = id; araddr = a; arlen = 4'(ln); arsize = 3'(sz); arburst = 2'(bt); arvalid = 1'b1;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [31:0] a, input int ln, input int sz, input int bt);
    awid = id; awaddr = a; awlen = 4'(ln); awsize = 3'(sz); awburst = 2'(bt); awvalid = 1'b1;
  endtask

  task automatic wait_ar_hs();
    int k = 0;
    #1;
    while (!arready && k < 50) begin @(negedge aclk); #1; k++; end
    check("arready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic wait_aw_hs();
    int k = 0;
    #1;
    while (!awready && k < 50) begin @(negedge aclk); #1; k++; end
    check("awready", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic read_beats(input logic [3:0] id, input logic [31:0] addr, input int ln,
                            input int sz, input int bt, input int stall_at);
    logic [31:0] a, exp;
    logic [1:0]  r;
    int k;
    a = addr;
    for (int b = 0; b <= ln; b++) begin
      k = 0;
      #1;
      while (!rvalid && k < 50) begin @(negedge aclk); #1; k++; end
      check("rvalid", 32'(rvalid), 32'd1);
`ifndef AXI_SLAVE_RAND_STALL_EN
      if (b == 0) check("r_latency", 32'(k), 32'd0);
`endif
      r = m_resp(a, sz, ln, bt);
      exp = 32'hxxxxxxxx;
      if (r != 2'b00) exp = 32'd0;
      else if (ref_mem.exists(m_word(a))) exp = ref_mem[m_word(a)];
      if (!$isunknown(exp)) check("rdata", rdata, exp);
      check("rid", 32'(rid), 32'(id));
      check("rresp", 32'(rresp), 32'(r));
      check("rlast", 32'(rlast), 32'(b == ln));
      if (b == stall_at) begin
        repeat (5) begin
          @(negedge aclk); #1;
          check("stall_rvalid", 32'(rvalid), 32'd1);
          if (!$isunknown(exp)) check("stall_rdata", rdata, exp);
          check("stall_rlast", 32'(rlast), 32'(b == ln));
        end
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      a = m_next(a, sz, ln, bt);
    end
    #1;
    check("r_done", 32'(rvalid), 32'd0);
  endtask

  task automatic write_beats(input logic [3:0] id, input logic [31:0] addr, input int ln,
                             input int sz, input int bt, input int bad);
    logic [31:0] a, old;
    logic [1:0]  r, worst;
    logic        lst;
    int k, w;
    a = addr;
    worst = 2'b00;
    for (int b = 0; b <= ln; b++) begin
      lst = (bad >= 0) ? (b == bad) : (b == ln);
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = lst;
      k = 0;
      #1;
      while (!wready && k < 50) begin @(negedge aclk); #1; k++; end
      check("wready", 32'(wready), 32'd1);
      r = m_resp(a, sz, ln, bt);
      if (r == 2'b00) begin
        w = m_word(a);
        old = ref_mem.exists(w) ? ref_mem[w] : 32'hxxxxxxxx;
        for (int i = 0; i < 4; i++) if (ws[b][i]) old[8*i +: 8] = wd[b][8*i +: 8];
        ref_mem[w] = old;
      end
      if (r > worst) worst = r;
      if (lst != (b == ln) && worst < 2'b10) worst = 2'b10;
      @(negedge aclk);
      a = m_next(a, sz, ln, bt);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    k = 0;
    #1;
    while (!bvalid && k < 50) begin @(negedge aclk); #1; k++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(worst));
    @(negedge aclk);
    bready = 1'b0;
    #1;
    check("b_done", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int ln,
                         input int sz, input int bt, input int stall_at);
    set_ar(id, a, ln, sz, bt);
    wait_ar_hs();
    read_beats(id, a, ln, sz, bt, stall_at);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int ln,
                          input int sz, input int bt, input int bad);
    set_aw(id, a, ln, sz, bt);
    wait_aw_hs();
    write_beats(id, a, ln, sz, bt, bad);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rid_v;
    logic [31:0] raddr;
    int rlen, rsz, rbt, rbad, rstall;

    // Reset: every output low.
    repeat (3) @(negedge aclk);
    #1;
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // Simultaneous AR/AW after reset: read wins, then write wins.
    set_ar(4'd5, BASE, 0, 2, 1);
    set_aw(4'd9, BASE + 32'h100, 0, 2, 1);
    #1;
    check("arb1_arready", 32'(arready), 32'd1);
    check("arb1_awready", 32'(awready), 32'd0);
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    read_beats(4'd5, BASE, 0, 2, 1, -1);
    set_ar(4'd5, BASE, 0, 2, 1);
    set_aw(4'd9, BASE + 32'h100, 0, 2, 1);
    #1;
    check("arb2_awready", 32'(awready), 32'd1);
    check("arb2_arready", 32'(arready), 32'd0);
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
    write_beats(4'd9, BASE + 32'h100, 0, 2, 1, -1);

    // Fill a 64-word window; the first W beat is offered before AW.
    for (int blk = 0; blk < 4; blk++) begin
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      set_aw(4'(blk), BASE + 32'(blk * 64), 15, 2, 1);
      if (blk == 0) begin
        wvalid = 1'b1; wdata = wd[0]; wstrb = ws[0];
        #1;
        check("w_early_wready", 32'(wready), 32'd0);
      end
      wait_aw_hs();
      write_beats(4'(blk), BASE + 32'(blk * 64), 15, 2, 1, -1);
    end

    // Data 1..4 at BASE, read back INCR, then WRAP from BASE+8.
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    do_write(4'd3, BASE, 3, 2, 1, -1);
    do_read(4'd6, BASE, 3, 2, 1, -1);
    do_read(4'd7, BASE + 32'h8, 3, 2, 2, -1);

    // Out-of-range read and write: DECERR, memory at BASE unchanged.
    do_read(4'd1, 32'h0000_0000, 1, 2, 1, -1);
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(4'd2, 32'h0000_0000, 0, 2, 1, -1);
    do_read(4'd2, BASE, 3, 2, 1, -1);

    // rready held low for 5 cycles mid-burst.
    do_read(4'd8, BASE, 7, 2, 1, 3);

    // Strobed write over a full word.
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    do_write(4'd4, BASE + 32'd80, 0, 2, 1, -1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(4'd4, BASE + 32'd80, 0, 2, 1, -1);
    check("strobe_model", ref_mem[20], 32'h11BB_33DD);
    do_read(4'd4, BASE + 32'd80, 0, 2, 1, -1);

    // Early wlast, oversize beat and illegal wrap length.
    for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(4'd10, BASE + 32'h40, 3, 2, 1, 1);
    do_read(4'd11, BASE, 1, 3, 1, -1);
    do_read(4'd12, BASE, 2, 2, 2, -1);

    // Reset in the middle of a read burst.
    set_ar(4'd2, BASE, 7, 2, 1);
    wait_ar_hs();
    rready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_rlast", 32'(rlast), 32'd0);
    rready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    do_read(4'd13, BASE, 3, 2, 1, -1);

    // Randomized bursts inside the window, with occasional error cases.
    for (int it = 0; it < 60; it++) begin
      rid_v = 4'($urandom_range(0, 15));
      rbt   = $urandom_range(0, 2);
      rsz   = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (rbt == 2) begin
        case ($urandom_range(0, 4))
          0: rlen = 1; 1: rlen = 3; 2: rlen = 7; 3: rlen = 15;
          default: rlen = ($urandom_range(0, 1) == 0) ? 2 : 5;
        endcase
      end else begin
        rlen = $urandom_range(0, 15);
      end
      raddr = BASE + 32'($urandom_range(0, 47) * 4);
      if (rsz == 0) raddr = raddr + 32'($urandom_range(0, 3));
      if (rsz == 1) raddr = raddr + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 9) == 0) raddr = 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom_range(0, 15)); end
        rbad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rlen) : -1;
        do_write(rid_v, raddr, rlen, rsz, rbt, rbad);
      end else begin
        rstall = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rlen) : -1;
        do_read(rid_v, raddr, rlen, rsz, rbt, rstall);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
